// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master engine.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        STOP
    } i2c_master_state_t;

    typedef logic [1:0] i2c_quarter_t;

endpackage

// File: rtl/i2c_master_tick.sv
// SCL quarter-period prescaler: strobes on the last cycle of each quarter.
// With I2C_MASTER_STRETCH_EN defined, the end of q2 stalls while the slave holds SCL low.
module i2c_master_tick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_en,
    input  logic         i_qclr,
    input  logic         scl_i,
    output logic         o_stb,
    output i2c_quarter_t o_q
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    i2c_quarter_t  r_q;
    logic          w_last;
    logic          w_stall;

    assign w_last = (r_cnt == CW'(CLK_DIV - 1));

`ifdef I2C_MASTER_STRETCH_EN
    assign w_stall = w_last && (r_q == 2'd2) && !scl_i;
`else
    logic w_unused_scl;
    assign w_unused_scl = scl_i;
    assign w_stall      = 1'b0;
`endif

    assign o_stb = w_last && !w_stall;
    assign o_q   = r_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_q   <= 2'd0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_q   <= 2'd0;
        end else if (o_stb) begin
            r_cnt <= '0;
            r_q   <= i_qclr ? 2'd0 : r_q + 2'd1;
        end else if (!w_stall) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_master.sv
// I2C master engine: 7-bit address transactions of 0..MAX_LEN bytes, open-drain enables only.
// Optional clock stretching via I2C_MASTER_STRETCH_EN (handled in i2c_master_tick).
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [I2C_ADDR_W-1:0] addr,
    input  logic                  rw,
    input  logic [LEN_W-1:0]      len,
    input  logic [7:0]            wr_data,
    output logic                  wr_ready,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  nack,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  scl_oe,
    output logic                  sda_oe,
    output i2c_master_state_t     dbg_state
);

    i2c_master_state_t r_state, w_next;
    logic [7:0]        r_shift, r_rx, r_rd_data;
    logic [2:0]        r_bit;
    logic [LEN_W-1:0]  r_bytes, w_len_sat;
    logic              r_rw, r_ack, r_nack, r_done, r_wr_ready, r_rd_valid;
    logic              w_stb, w_qclr, w_accept, w_bit_end, w_tx_bit;
    i2c_quarter_t      w_q;

    i2c_master_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rstn   (rstn),
        .i_en   (r_state != IDLE),
        .i_qclr (w_qclr),
        .scl_i  (scl_i),
        .o_stb  (w_stb),
        .o_q    (w_q)
    );

    assign w_accept  = (r_state == IDLE) && start;
    assign w_bit_end = w_stb && (w_q == 2'd3);
    assign w_len_sat = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    // The first data bit goes out in the wr_ready cycle, straight from wr_data.
    assign w_tx_bit  = (r_state == WRITE && r_wr_ready) ? wr_data[7] : r_shift[7];

    always_comb begin
        w_next = r_state;
        w_qclr = 1'b0;
        case (r_state)
            IDLE:      if (start) w_next = START;
            START:     if (w_stb && w_q == 2'd1) begin
                           w_next = ADDR;
                           w_qclr = 1'b1;
                       end
            ADDR:      if (w_bit_end && r_bit == 3'd7) w_next = ADDR_ACK;
            ADDR_ACK:  if (w_bit_end) begin
                           if (r_ack || r_bytes == '0) w_next = STOP;
                           else if (r_rw)              w_next = READ;
                           else                        w_next = WRITE;
                       end
            WRITE:     if (w_bit_end && r_bit == 3'd7) w_next = WRITE_ACK;
            WRITE_ACK: if (w_bit_end) w_next = (r_ack || r_bytes == LEN_W'(1)) ? STOP : WRITE;
            READ:      if (w_bit_end && r_bit == 3'd7) w_next = READ_ACK;
            READ_ACK:  if (w_bit_end) w_next = (r_bytes == LEN_W'(1)) ? STOP : READ;
            STOP:      if (w_stb && w_q == 2'd2) begin
                           w_next = IDLE;
                           w_qclr = 1'b1;
                       end
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (r_state)
            START:     sda_oe = (w_q == 2'd1);
            ADDR, WRITE: begin
                scl_oe = ~w_q[1];
                sda_oe = ~w_tx_bit;
            end
            ADDR_ACK, WRITE_ACK, READ: scl_oe = ~w_q[1];
            READ_ACK: begin
                scl_oe = ~w_q[1];
                sda_oe = (r_bytes != LEN_W'(1));
            end
            STOP: begin
                scl_oe = (w_q == 2'd0);
                sda_oe = (w_q != 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_shift    <= 8'h00;
            r_rx       <= 8'h00;
            r_rd_data  <= 8'h00;
            r_bit      <= 3'd0;
            r_bytes    <= '0;
            r_rw       <= 1'b0;
            r_ack      <= 1'b0;
            r_nack     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_done     <= (r_state == STOP) && (w_next == IDLE);
            r_wr_ready <= (w_next == WRITE) && (r_state != WRITE);
            r_rd_valid <= (w_next == READ_ACK) && (r_state == READ);

            if (w_accept) begin
                r_shift <= {addr, rw};
                r_rw    <= rw;
                r_bytes <= w_len_sat;
                r_nack  <= 1'b0;
            end else if (r_wr_ready) begin
                r_shift <= wr_data;
            end else if (w_bit_end && (r_state == ADDR || r_state == WRITE)) begin
                r_shift <= {r_shift[6:0], 1'b0};
            end

            if (w_bit_end && (r_state == ADDR || r_state == WRITE || r_state == READ))
                r_bit <= r_bit + 3'd1;

            if (w_stb && w_q == 2'd2) begin
                if (r_state == READ) r_rx <= {r_rx[6:0], sda_i};
                if (r_state == ADDR_ACK || r_state == WRITE_ACK) r_ack <= sda_i;
            end

            if ((w_next == READ_ACK) && (r_state == READ)) r_rd_data <= r_rx;

            if (w_bit_end && r_ack && (r_state == ADDR_ACK || r_state == WRITE_ACK))
                r_nack <= 1'b1;

            if (w_bit_end && ((r_state == WRITE_ACK && !r_ack) || r_state == READ_ACK))
                r_bytes <= r_bytes - LEN_W'(1);
        end
    end

    // wr_ready, rd_valid and done are single-cycle pulses with no back-pressure:
    // wr_data must already be valid when wr_ready is high; rd_data is valid with rd_valid.
    assign wr_ready  = r_wr_ready;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign done      = r_done;
    assign nack      = r_nack;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

endmodule

// File: doc/i2c_master.md
# i2c_master

Parametrised I2C master engine and successor to the single-byte I2C controller. It runs complete 7-bit-address transactions of 0..MAX_LEN bytes in either direction, built from a programmable SCL prescaler, per-byte data handshakes and sticky NACK reporting. It sits between a register/host front-end and the open-drain pad cells, and drives only output-enable lines: oe=1 pulls the line low, oe=0 releases it.

## Interface
- CLK_DIV, 4: clk cycles per SCL quarter-period; legal values are 2 or more. The bit period is 4*CLK_DIV.
- MAX_LEN, 16: maximum bytes per transaction.
- LEN_W, $clog2(MAX_LEN+1): width of `len`.
- `clk`  in  1  the single clock. The block is fully synchronous to it.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  transaction request. It is accepted only in a cycle where busy=0.
- `addr`  in  7  slave address, latched on accept.
- `rw`  in  1  direction, latched on accept: 0 = write, 1 = read.
- `len`  in  LEN_W  byte count, latched on accept. 0 means an address-only probe.
- `wr_data`  in  8  next write byte. It is sampled in the cycle wr_ready=1.
- `wr_ready`  out  1  one-cycle pulse: wr_data has been consumed.
- `rd_data`  out  8  last received byte. It holds its value until the next byte arrives.
- `rd_valid`  out  1  one-cycle pulse: rd_data has been updated.
- `busy`  out  1  a transaction is in progress.
- `done`  out  1  one-cycle pulse: the STOP condition is complete.
- `nack`  out  1  sticky flag: the slave NACKed. It is cleared when the next start is accepted.
- `scl_i`, `sda_i`  in  1  synchronised bus line levels.
- `scl_oe`, `sda_oe`  out  1  pull-low enables.

## Operation
- States: IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP.
- Every bit occupies quarters q0..q3:
  - SCL is driven low in q0–q1 and released in q2–q3.
  - SDA changes only at the start of q0.
  - sda_i is sampled in the last cycle of q2.
- IDLE:
  - All outputs are released.
  - An accepted start latches addr, rw and len, clears nack, and moves to START.
- START: two quarters.
  - Quarter 1: both lines are released.
  - Quarter 2: sda_oe=1, SCL stays released.
  - Then ADDR.
- ADDR: shifts {addr, rw} out MSB first, then moves to ADDR_ACK. During that acknowledge bit SDA is released and sda_i is sampled.
- Acknowledge handling:
  - A sampled 1 on any acknowledge bit from the slave sets nack and goes to STOP.
  - On ACK with len=0, go to STOP.
  - On ACK with rw=0, go to WRITE.
  - On ACK with rw=1, go to READ.
- WRITE:
  - wr_ready pulses in the first cycle of the byte's q0, and wr_data is loaded in that cycle.
  - 8 bits are sent MSB first, then WRITE_ACK follows.
  - On ACK, the byte counter decrements. At 0 the block goes to STOP; otherwise it goes to WRITE.
- READ:
  - SDA is released and 8 bits are sampled MSB first.
  - rd_valid pulses in the first cycle of READ_ACK.
  - In READ_ACK the master drives ACK (sda_oe=1) if bytes remain, and NACK (released) on the last byte.
  - After the last byte the block goes to STOP.
- STOP: three quarters.
  - Quarter 1: SCL low, SDA low.
  - Quarter 2: SCL released, SDA low.
  - Quarter 3: both released.
  - Then IDLE.
- start is ignored while busy=1.
- A len value above MAX_LEN saturates to MAX_LEN.

## Timing
- Reset values:
  - busy=0, done=0, nack=0, wr_ready=0, rd_valid=0, rd_data=8'h00.
  - scl_oe=0, sda_oe=0.
  - State IDLE, prescaler=0.
- Reset mid-transaction: both oe lines release asynchronously in the same cycle. No STOP is issued and no done pulse is generated.
- Latency:
  - start is accepted in cycle N. busy=1 from N+1, and the START condition begins at N+1.
  - A transaction of n bytes lasts CLK_DIV*(41+36n) cycles from busy rising to the done pulse.
  - busy falls in the same cycle as done.
  - After an address NACK: CLK_DIV*41 cycles.
- done and rd_valid are never asserted in the same cycle as wr_ready.

## Configuration
- I2C_MASTER_STRETCH_EN defined: clock stretching is honoured.
  - At the end of q2 the prescaler stalls while scl_i=0 (slave holding SCL low).
  - q3 starts in the cycle after scl_i reads 1.
  - The transaction length grows by the stall cycles.
- I2C_MASTER_STRETCH_EN undefined: scl_i is ignored and timing is fixed exactly as in Timing.

## Structure
- Package i2c_pkg holds:
  - typedef i2c_master_state_t (enum of the states above).
  - typedef i2c_quarter_t (2-bit quarter index).
  - Constant I2C_ADDR_W=7.
- Sub-module i2c_master_tick:
  - A prescaler counting 0..CLK_DIV-1.
  - Outputs a quarter strobe and the quarter index.
  - Contains the stretch stall logic under the macro.
- The shifter, byte counter and FSM live in i2c_master.

## Test plan
- Write, CLK_DIV=4, addr=0x50, rw=0, len=2, data 0xA5,0x3C, slave ACKs → SDA carries 0xA0, 0xA5, 0x3C; two wr_ready pulses; done at 452 cycles; nack=0.
- Read, addr=0x50, rw=1, len=3, slave sends 0x11,0x22,0x33 → rd_valid ×3 with those values; master sends ACK, ACK, NACK; then STOP.
- Address NACK (slave silent), len=2 → nack=1, no wr_ready, STOP follows immediately, done at 164 cycles.
- Probe with len=0 and ACK → address byte only, then STOP; done at 164 cycles; nack=0.
- rstn pulsed low mid-byte during a write → scl_oe and sda_oe are 0 in the same cycle and all outputs take their reset values; a new start then completes normally.
- Stretch: with the macro defined, scl_i is held low for 20 cycles at one q2 → done is delayed by exactly 20 cycles. Without the macro there is no delay.
